// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider for the EX-stage DIV/DIVU path.
// Returns {remainder, quotient} with ready after WIDTH iterations; annul aborts at any time.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DIVZERO = 2'd1,
        S_ON      = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CW-1:0]      counter_r, counter_s;
    logic [2*WIDTH:0]   shreg_r, shreg_s;
    logic [WIDTH-1:0]   divisor_r, divisor_s;
    logic               neg_q_r, neg_q_s;
    logic               neg_r_r, neg_r_s;
    logic [2*WIDTH-1:0] result_r, result_s;
    logic               ready_r, ready_s;
    logic [2*WIDTH:0]   shifted_s;
    logic [WIDTH:0]     trial_s;
    logic               op1_neg_s;
    logic               op2_neg_s;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        logic [WIDTH-1:0] r;
        if (n) begin
            r = ~v + WIDTH'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction

    assign result = result_r;
    assign ready  = ready_r;

    // Next-state, datapath and output computation
    always_comb begin
        state_s   = state_r;
        counter_s = counter_r;
        shreg_s   = shreg_r;
        divisor_s = divisor_r;
        neg_q_s   = neg_q_r;
        neg_r_s   = neg_r_r;
        result_s  = '0;
        ready_s   = 1'b0;
        op1_neg_s = signed_div & opdata1[WIDTH-1];
        op2_neg_s = signed_div & opdata2[WIDTH-1];
        shifted_s = {shreg_r[2*WIDTH-1:0], 1'b0};
        trial_s   = shifted_s[2*WIDTH:WIDTH] - {1'b0, divisor_r};

        if (annul) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        neg_r_s   = op1_neg_s;
                        neg_q_s   = op1_neg_s ^ op2_neg_s;
                        shreg_s   = {{(WIDTH+1){1'b0}}, neg_if(opdata1, op1_neg_s)};
                        divisor_s = neg_if(opdata2, op2_neg_s);
                        counter_s = '0;
                        if (opdata2 == '0) begin
                            state_s = S_DIVZERO;
                        end else begin
                            state_s = S_ON;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_ON: begin
                    // Top bit of the trial difference is its sign: clear means divisor fits
                    if (!trial_s[WIDTH]) begin
                        shreg_s = {trial_s, shifted_s[WIDTH-1:1], 1'b1};
                    end else begin
                        shreg_s = shifted_s;
                    end
                    counter_s = counter_r + CW'(1);
                    if (counter_r == CW'(WIDTH - 1)) begin
                        state_s = S_END;
                    end else begin
                        state_s = S_ON;
                    end
                end
                S_DIVZERO: begin
                    shreg_s = '0;
                    state_s = S_END;
                end
                S_END: begin
                    if (!ready_r) begin
                        result_s = {neg_if(shreg_r[2*WIDTH-1:WIDTH], neg_r_r),
                                    neg_if(shreg_r[WIDTH-1:0], neg_q_r)};
                        ready_s  = 1'b1;
                        state_s  = S_END;
                    end else if (start) begin
                        result_s = result_r;
                        ready_s  = 1'b1;
                        state_s  = S_END;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= S_IDLE;
            counter_r <= '0;
            shreg_r   <= '0;
            divisor_r <= '0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            result_r  <= '0;
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            counter_r <= counter_s;
            shreg_r   <= shreg_s;
            divisor_r <= divisor_s;
            neg_q_r   <= neg_q_s;
            neg_r_r   <= neg_r_s;
            result_r  <= result_s;
            ready_r   <= ready_s;
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Directed and randomised self-checking bench for div_radix2.
// Expected results come from hand-computed constants and a 64-bit arithmetic model.
module tb_div_radix2;

    logic        clk;
    logic        resetn;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int errors = 0;
    int checks = 0;

    div_radix2 #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = $signed({32'd0, a});
            sb = $signed({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Accept one op, scramble operands afterwards, and check latency, result and release
    task automatic do_op(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_lat, input bit hold);
        int n;
        signed_div = sg;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        tick();
        opdata1    = ~a;
        opdata2    = b ^ 32'h5A5A_0001;
        signed_div = ~sg;
        if (!hold) start = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        if (hold) begin
            tick();
            chk({tag, "_hold_rdy"}, {63'd0, ready}, 64'd1);
            chk({tag, "_hold_res"}, result, exp_res);
            start = 1'b0;
        end
        tick();
        chk({tag, "_rel_rdy"}, {63'd0, ready}, 64'd0);
        chk({tag, "_rel_res"}, result, 64'd0);
    endtask

    initial begin
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        resetn     = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd0;
        opdata2    = 32'd0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (2) tick();
        chk("reset_rdy", {63'd0, ready}, 64'd0);
        chk("reset_res", result, 64'd0);
        resetn = 1'b1;
        tick();
        chk("idle_rdy", {63'd0, ready}, 64'd0);

        do_op("u100_7",    1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33, 1'b1);
        do_op("s_m7_2",    1'b1, 32'hFFFFFFF9,  32'h2,         64'hFFFFFFFF_FFFFFFFD, 33, 1'b1);
        do_op("u_m7_2",    1'b0, 32'hFFFFFFF9,  32'h2,         64'h00000001_7FFFFFFC, 33, 1'b1);
        do_op("s_min_m1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 33, 1'b1);
        do_op("s_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 33, 1'b1);
        do_op("s_dz",      1'b1, 32'h80000001,  32'd0,         64'd0,                  2, 1'b1);
        do_op("u_dz",      1'b0, 32'hDEADBEEF,  32'd0,         64'd0,                  2, 1'b1);
        do_op("drop_start",1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 33, 1'b0);

        // Annul partway through the iterations
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        tick();
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        chk("annul_on_rdy", {63'd0, ready}, 64'd0);
        chk("annul_on_res", result, 64'd0);
        annul = 1'b0;
        n = 0;
        repeat (40) begin
            tick();
            if (ready !== 1'b0) n++;
        end
        chk("annul_quiet", 64'(n), 64'd0);
        do_op("fresh", 1'b0, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 33, 1'b1);

        // Annul while the result is being held
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        tick();
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("annul_end_lat", 64'(n), 64'd33);
        annul = 1'b1;
        tick();
        chk("annul_end_rdy", {63'd0, ready}, 64'd0);
        chk("annul_end_res", result, 64'd0);
        annul = 1'b0;
        start = 1'b0;
        tick();

        // Asynchronous reset mid-iteration, then a normal op
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        tick();
        repeat (5) tick();
        #2 resetn = 1'b0;
        #1;
        chk("arst_on_rdy", {63'd0, ready}, 64'd0);
        chk("arst_on_res", result, 64'd0);
        start = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        do_op("after_rst", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1'b1);

        // Asynchronous reset while a non-zero result is held
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        start   = 1'b1;
        tick();
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("arst_end_pre", result, 64'h00000002_0000000E);
        #2 resetn = 1'b0;
        #1;
        chk("arst_end_rdy", {63'd0, ready}, 64'd0);
        chk("arst_end_res", result, 64'd0);
        start = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Randomised operations against the arithmetic model
        for (int i = 0; i < 200; i++) begin
            sg = 1'($urandom_range(1, 0));
            a  = $urandom();
            b  = $urandom();
            if ((i % 16) == 3) b = 32'd0;
            if ((i % 16) == 7) b = 32'hFFFFFFFF;
            if ((i % 16) == 9) a = 32'h80000000;
            if ((i % 16) == 11) b = b >> $urandom_range(31, 0);
            if ((i % 16) == 13) b = 32'd1;
            do_op("rand", sg, a, b, model(sg, a, b), (b == 32'd0) ? 2 : 33,
                  1'($urandom_range(1, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
